// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared by the load/store unit and its helpers.
//   XLEN        - data/address width (only 32 is supported)
//   F3_*        - funct3 encodings for loads and stores
//   lsu_state_e - LSU sequencing states
//   f3_supported() - true for the five legal load/store funct3 codes
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_e;

  function automatic logic f3_supported(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational byte-lane steering for the LSU.
// Store side turns funct3 + low address bits + rs2 into lane strobes and
// replicated write data; load side picks the byte/half out of the returned
// word and sign- or zero-extends it.
// Ports:
//   i_st_funct3, i_st_addr_lo, i_st_wdata -> o_st_wstrb, o_st_wdata
//   i_ld_funct3, i_ld_addr_lo, i_ld_rdata -> o_ld_rdata
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]      i_st_funct3,
  input  logic [1:0]      i_st_addr_lo,
  input  logic [XLEN-1:0] i_st_wdata,
  output logic [3:0]      o_st_wstrb,
  output logic [XLEN-1:0] o_st_wdata,
  input  logic [2:0]      i_ld_funct3,
  input  logic [1:0]      i_ld_addr_lo,
  input  logic [XLEN-1:0] i_ld_rdata,
  output logic [XLEN-1:0] o_ld_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store size comes from funct3[1:0]; the unsigned bit has no meaning here.
  always_comb begin
    o_st_wstrb = 4'b0000;
    o_st_wdata = i_st_wdata;
    case (i_st_funct3[1:0])
      2'b00: begin
        o_st_wstrb = 4'b0001 << i_st_addr_lo;
        o_st_wdata = {4{i_st_wdata[7:0]}};
      end
      2'b01: begin
        o_st_wstrb = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_st_wdata = {2{i_st_wdata[15:0]}};
      end
      2'b10: begin
        o_st_wstrb = 4'b1111;
      end
      default: begin
        o_st_wstrb = 4'b0000;
      end
    endcase
  end

  always_comb begin
    w_byte = i_ld_rdata[7:0];
    case (i_ld_addr_lo)
      2'd0:    w_byte = i_ld_rdata[7:0];
      2'd1:    w_byte = i_ld_rdata[15:8];
      2'd2:    w_byte = i_ld_rdata[23:16];
      default: w_byte = i_ld_rdata[31:24];
    endcase
    w_half = i_ld_addr_lo[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
  end

  always_comb begin
    o_ld_rdata = '0;
    case (i_ld_funct3)
      F3_B:    o_ld_rdata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_ld_rdata = {24'd0, w_byte};
      F3_H:    o_ld_rdata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_ld_rdata = {16'd0, w_half};
      F3_W:    o_ld_rdata = i_ld_rdata;
      default: o_ld_rdata = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: iterative load/store unit behind the ALU. Accepts one access at a
// time, issues a single word-wide req/gnt/rvalid bus transaction and returns
// extended load data or store completion as a one-cycle response pulse.
// All outputs are registered.
// Parameters: XLEN (32 only), TIMEOUT (>= 2, cycles allowed in REQ+WAIT).
// Ports:
//   clk, rst (synchronous, active high)
//   req_valid/req_ready, req_is_store, req_funct3, req_addr, req_wdata
//   resp_valid, resp_rdata, resp_err
//   mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, mem_gnt,
//   mem_rvalid, mem_rdata
// Build option: LSU_MISALIGN_TRAP_EN - when defined, misaligned H/HU/W
// accesses return resp_err without touching the bus; when undefined the low
// address bits are forced aligned and the access proceeds.
module lsu
  import riscv_pkg::*;
#(
  parameter int XLEN    = riscv_pkg::XLEN,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_e r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  logic            r_is_store;
  logic [2:0]      r_funct3;
  logic [1:0]      r_addr_lo;

  logic            r_req_ready;
  logic            r_resp_valid, r_resp_err;
  logic [XLEN-1:0] r_resp_rdata;
  logic            r_mem_req, r_mem_we;
  logic [XLEN-1:0] r_mem_addr, r_mem_wdata;
  logic [3:0]      r_mem_wstrb;

  logic            w_resp_err_nxt;
  logic [XLEN-1:0] w_resp_rdata_nxt;
  logic            w_mem_we_nxt;
  logic [XLEN-1:0] w_mem_addr_nxt, w_mem_wdata_nxt;
  logic [3:0]      w_mem_wstrb_nxt;

  logic            w_accept;
  logic            w_trap;
  logic [1:0]      w_addr_lo_eff;
  logic [3:0]      w_st_wstrb;
  logic [XLEN-1:0] w_st_wdata;
  logic [XLEN-1:0] w_ld_rdata;

  assign w_accept = (r_state == LSU_IDLE) && req_valid && r_req_ready;

  // Halfwords ignore addr[0] and words ignore addr[1:0], so an unaligned
  // request simply lands on the containing aligned unit.
  always_comb begin
    w_addr_lo_eff = req_addr[1:0];
    if ((req_funct3 == F3_H) || (req_funct3 == F3_HU)) begin
      w_addr_lo_eff = {req_addr[1], 1'b0};
    end else if (req_funct3 == F3_W) begin
      w_addr_lo_eff = 2'b00;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]) ||
                  ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
`else
  assign w_trap = 1'b0;
`endif

  lsu_align u_align (
    .i_st_funct3  (req_funct3),
    .i_st_addr_lo (w_addr_lo_eff),
    .i_st_wdata   (req_wdata),
    .o_st_wstrb   (w_st_wstrb),
    .o_st_wdata   (w_st_wdata),
    .i_ld_funct3  (r_funct3),
    .i_ld_addr_lo (r_addr_lo),
    .i_ld_rdata   (mem_rdata),
    .o_ld_rdata   (w_ld_rdata)
  );

  // Bus fields default to zero and are only held while REQ persists, so they
  // read as idle once the request has been granted or abandoned.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_resp_err_nxt   = 1'b0;
    w_resp_rdata_nxt = '0;
    w_mem_we_nxt     = 1'b0;
    w_mem_addr_nxt   = '0;
    w_mem_wstrb_nxt  = 4'b0000;
    w_mem_wdata_nxt  = '0;
    case (r_state)
      LSU_IDLE: begin
        if (w_accept) begin
          if (!f3_supported(req_funct3) || w_trap) begin
            w_state_nxt    = LSU_RESP;
            w_resp_err_nxt = 1'b1;
          end else begin
            w_state_nxt     = LSU_REQ;
            w_cnt_nxt       = '0;
            w_mem_we_nxt    = req_is_store;
            w_mem_addr_nxt  = {req_addr[XLEN-1:2], 2'b00};
            w_mem_wstrb_nxt = req_is_store ? w_st_wstrb : 4'b0000;
            w_mem_wdata_nxt = req_is_store ? w_st_wdata : '0;
          end
        end
      end
      LSU_REQ: begin
        if (mem_gnt && r_is_store) begin
          w_state_nxt = LSU_RESP;
        end else if (r_cnt == CNT_LAST) begin
          // A load granted on its last allowed cycle cannot finish in time.
          w_state_nxt    = LSU_RESP;
          w_resp_err_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (mem_gnt) begin
            w_state_nxt = LSU_WAIT;
          end else begin
            w_mem_we_nxt    = r_mem_we;
            w_mem_addr_nxt  = r_mem_addr;
            w_mem_wstrb_nxt = r_mem_wstrb;
            w_mem_wdata_nxt = r_mem_wdata;
          end
        end
      end
      LSU_WAIT: begin
        if (mem_rvalid) begin
          w_state_nxt      = LSU_RESP;
          w_resp_rdata_nxt = w_ld_rdata;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt    = LSU_RESP;
          w_resp_err_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      LSU_RESP: begin
        w_state_nxt = LSU_IDLE;
      end
      default: begin
        w_state_nxt = LSU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= LSU_IDLE;
      r_cnt        <= '0;
      r_is_store   <= 1'b0;
      r_funct3     <= 3'b000;
      r_addr_lo    <= 2'b00;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wstrb  <= 4'b0000;
      r_mem_wdata  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      if (w_accept) begin
        r_is_store <= req_is_store;
        r_funct3   <= req_funct3;
        r_addr_lo  <= w_addr_lo_eff;
      end
      r_req_ready  <= (w_state_nxt == LSU_IDLE);
      r_resp_valid <= (w_state_nxt == LSU_RESP);
      r_resp_err   <= w_resp_err_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_mem_req    <= (w_state_nxt == LSU_REQ);
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wstrb  <= w_mem_wstrb_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wstrb  = r_mem_wstrb;
  assign mem_wdata  = r_mem_wdata;

endmodule
